// File: rtl/aoi4_stim_seq.sv
// ---------------------------------------------------------------------------
// aoi4_stim_seq
//
// Stimulus sequencer for the 4-input AND-OR-INVERT cell. It walks all 16
// input combinations onto a/b/c/d in binary or Gray order. Each vector is
// held for HOLD_CYCLES clocks, and sample pulses in the last cycle of each
// hold window.
//
// Optional checker, built in with `define AOI4_STIM_CHECK_EN:
//   - In each sample cycle, y_in is compared against ~((a&b)|(c&d)).
//   - Mismatches are counted in err_cnt.
//   - pass reports err_cnt==0 when the sweep completes.
// Without the macro, y_in is ignored, err_cnt stays 0 and pass reads 1
// after every completed sweep.
//
// Parameters:
//   HOLD_CYCLES  cycles each vector is held (1..2^CNT_W)
//   CNT_W        hold counter width
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     sweep request, only honoured in IDLE
//   mode      0 = binary order, 1 = Gray order (latched at start)
//   y_in      AOI output under test (checker only)
//   a,b,c,d   stimulus, a is the MSB of the vector
//   vec_idx   index of the vector being driven
//   sample    last cycle of the current hold window
//   busy      sweep in progress
//   done      one-cycle end-of-sweep pulse
//   err_cnt   mismatch count of the current/last sweep
//   pass      verdict of the last completed sweep
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stimulus parked at 0000, waiting for start
// RUN   | driving vectors 0..15, each for HOLD_CYCLES clocks
// DONE  | single-cycle end pulse, verdict captured, back to IDLE
// ---------------------------------------------------------------------------
module aoi4_stim_seq #(
    parameter int HOLD_CYCLES = 100,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] vec_idx,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_cnt,
    output logic       pass
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    // With a one-cycle hold, every cycle of the sweep is a sample cycle.
    localparam logic             HOLD_ONE = (HOLD_CYCLES == 1);

    state_t           state_q;
    logic             mode_q;
    logic [3:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       abcd_q;
    logic             sample_q;
    logic             busy_q;
    logic             done_q;
    logic [4:0]       err_q;
    logic             pass_q;

    logic [3:0]       vec_nxt;
    logic [3:0]       abcd_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       err_d;

    always_comb begin
        vec_nxt  = vec_q + 4'd1;
        abcd_nxt = mode_q ? (vec_nxt ^ {1'b0, vec_nxt[3:1]}) : vec_nxt;
        cnt_inc  = cnt_q + CNT_W'(1);
    end

`ifdef AOI4_STIM_CHECK_EN
    logic aoi_exp;
    always_comb begin
        aoi_exp = ~((abcd_q[3] & abcd_q[2]) | (abcd_q[1] & abcd_q[0]));
        // At most 16 sample cycles per sweep, so 5 bits cannot wrap.
        err_d   = err_q + 5'(y_in != aoi_exp);
    end
`else
    logic unused_y_in;
    assign unused_y_in = y_in;
    assign err_d       = 5'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            vec_q    <= 4'd0;
            cnt_q    <= '0;
            abcd_q   <= 4'd0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 5'd0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    abcd_q   <= 4'd0;
                    sample_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    if (start) begin
                        state_q  <= S_RUN;
                        mode_q   <= mode;
                        vec_q    <= 4'd0;
                        cnt_q    <= '0;
                        err_q    <= 5'd0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        sample_q <= HOLD_ONE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        err_q <= err_d;
                        cnt_q <= '0;
                        if (vec_q != 4'd15) begin
                            vec_q    <= vec_nxt;
                            abcd_q   <= abcd_nxt;
                            sample_q <= HOLD_ONE;
                        end else begin
                            state_q  <= S_DONE;
                            abcd_q   <= 4'd0;
                            sample_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            // Include a mismatch on the final vector in the verdict.
                            pass_q   <= (err_d == 5'd0);
                        end
                    end else begin
                        cnt_q    <= cnt_inc;
                        sample_q <= (cnt_inc == CNT_LAST);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    abcd_q   <= 4'd0;
                    sample_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign a       = abcd_q[3];
    assign b       = abcd_q[2];
    assign c       = abcd_q[1];
    assign d       = abcd_q[0];
    assign vec_idx = vec_q;
    assign sample  = sample_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_aoi4_stim_seq.sv
module tb_aoi4_stim_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance with HOLD_CYCLES=4
    logic       rst4_n, start4, mode4, y4;
    logic       a4, b4, c4, d4;
    logic [3:0] vi4;
    logic       s4, bz4, dn4;
    logic [4:0] ec4;
    logic       p4;
    int         fault4 = 0;  // 0 correct AOI, 1 inverted, 2 stuck at 1

    always_comb begin
        case (fault4)
            1:       y4 = (a4 & b4) | (c4 & d4);
            2:       y4 = 1'b1;
            default: y4 = ~((a4 & b4) | (c4 & d4));
        endcase
    end

    aoi4_stim_seq #(.HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .mode(mode4), .y_in(y4),
        .a(a4), .b(b4), .c(c4), .d(d4), .vec_idx(vi4), .sample(s4),
        .busy(bz4), .done(dn4), .err_cnt(ec4), .pass(p4)
    );

    // Instance with HOLD_CYCLES=1
    logic       rst1_n, start1, mode1, y1;
    logic       a1, b1, c1, d1;
    logic [3:0] vi1;
    logic       s1, bz1, dn1;
    logic [4:0] ec1;
    logic       p1;

    assign y1 = ~((a1 & b1) | (c1 & d1));

    aoi4_stim_seq #(.HOLD_CYCLES(1), .CNT_W(4)) u_h1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .mode(mode1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(vi1), .sample(s1),
        .busy(bz1), .done(dn1), .err_cnt(ec1), .pass(p1)
    );

    function automatic logic [3:0] exp_vec(input logic [3:0] i, input logic m);
        return m ? (i ^ (i >> 1)) : i;
    endfunction

    function automatic int exp_err(input int f);
`ifdef AOI4_STIM_CHECK_EN
        if (f == 1) return 16;
        if (f == 2) return 7;
        return 0;
`else
        return (f > 100) ? 1 : 0;
`endif
    endfunction

    // The caller is at a negedge with the H4 instance in IDLE.
    task automatic run_sweep4(input logic m, input int f, input bit hold_start, input string tag);
        int         e;
        logic       ep;
        logic [10:0] got, exp;
        int         n;
        e      = exp_err(f);
        ep     = (e == 0);
        fault4 = f;
        mode4  = m;
        start4 = 1'b1;
        @(negedge clk);
        if (!hold_start) start4 = 1'b0;
        mode4 = ~m;
        checks++;
        if (p4 !== 1'b0 || ec4 !== 5'd0) begin
            failures++;
            $display("FAIL %s clear_on_start: pass=%b err=%0d required pass=0 err=0", tag, p4, ec4);
        end
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 4; k++) begin
                got = {a4, b4, c4, d4, vi4, s4, bz4, dn4};
                exp = {exp_vec(4'(v), m), 4'(v), (k == 3), 1'b1, 1'b0};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL %s vec%0d_cyc%0d: {abcd,idx,smp,busy,done}=%b required %b", tag, v, k, got, exp);
                end
                @(negedge clk);
            end
        end
        checks++;
        if ({dn4, bz4, s4, a4, b4, c4, d4} !== 7'b1000000) begin
            failures++;
            $display("FAIL %s done_cycle: {done,busy,smp,abcd}=%b required 1000000", tag, {dn4, bz4, s4, a4, b4, c4, d4});
        end
        checks++;
        if (ec4 !== 5'(e) || p4 !== ep) begin
            failures++;
            $display("FAIL %s verdict: err=%0d pass=%b required err=%0d pass=%b", tag, ec4, p4, e, ep);
        end
        @(negedge clk);
        checks++;
        if ({dn4, bz4} !== 2'b00 || p4 !== ep || ec4 !== 5'(e)) begin
            failures++;
            $display("FAIL %s idle_after: done=%b busy=%b pass=%b err=%0d required 0 0 %b %0d", tag, dn4, bz4, p4, ec4, ep, e);
        end
        if (hold_start) begin
            @(negedge clk);
            checks++;
            if (bz4 !== 1'b1 || vi4 !== 4'd0) begin
                failures++;
                $display("FAIL %s restart: busy=%b idx=%0d required busy=1 idx=0", tag, bz4, vi4);
            end
            start4 = 1'b0;
            n = 0;
            while (!dn4 && n < 200) begin
                if (bz4) n++;
                @(negedge clk);
            end
            checks++;
            if (n !== 64 || dn4 !== 1'b1) begin
                failures++;
                $display("FAIL %s busy_len: busy_cycles=%0d done=%b required 64 1", tag, n, dn4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst4_n = 1'b0; rst1_n = 1'b0;
        start4 = 1'b1; start1 = 1'b1; mode4 = 1'b0; mode1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a4, b4, c4, d4, vi4, s4, bz4, dn4, ec4, p4} !== 18'd0) begin
            failures++;
            $display("FAIL reset_h4: outputs=%b required 0", {a4, b4, c4, d4, vi4, s4, bz4, dn4, ec4, p4});
        end
        checks++;
        if ({a1, b1, c1, d1, vi1, s1, bz1, dn1, ec1, p1} !== 18'd0) begin
            failures++;
            $display("FAIL reset_h1: outputs=%b required 0", {a1, b1, c1, d1, vi1, s1, bz1, dn1, ec1, p1});
        end
        start4 = 1'b0; start1 = 1'b0;
        rst4_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bz4 !== 1'b0 || bz1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy4=%b busy1=%b required 0 0", bz4, bz1);
        end
    endtask

    task automatic test_binary();
        run_sweep4(1'b0, 0, 1'b0, "binary");
    endtask

    task automatic test_gray();
        run_sweep4(1'b1, 0, 1'b0, "gray");
    endtask

    task automatic test_check_faults();
        run_sweep4(1'b0, 1, 1'b0, "inverted");
        run_sweep4(1'b1, 2, 1'b0, "stuck1");
        run_sweep4(1'b0, 0, 1'b0, "recover");
    endtask

    task automatic test_mid_reset();
        int n;
        int dones;
        fault4 = 0;
        mode4  = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (vi4 !== 4'd5 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (vi4 !== 4'd5 || {a4, b4, c4, d4} !== 4'd5) begin
            failures++;
            $display("FAIL midreset_reach5: idx=%0d abcd=%b required 5 0101", vi4, {a4, b4, c4, d4});
        end
        rst4_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        checks++;
        if ({a4, b4, c4, d4, vi4, s4, bz4, dn4, ec4, p4} !== 18'd0) begin
            failures++;
            $display("FAIL midreset_values: outputs=%b required 0", {a4, b4, c4, d4, vi4, s4, bz4, dn4, ec4, p4});
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (dn4 || bz4) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: active_cycles=%0d required 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        run_sweep4(1'b0, 0, 1'b1, "held_start");
    endtask

    task automatic test_hold1();
        logic [10:0] got, exp;
        mode1  = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int v = 0; v < 16; v++) begin
            got = {a1, b1, c1, d1, vi1, s1, bz1, dn1};
            exp = {4'(v), 4'(v), 1'b1, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL hold1_vec%0d: {abcd,idx,smp,busy,done}=%b required %b", v, got, exp);
            end
            @(negedge clk);
        end
        checks++;
        if ({dn1, bz1, s1, a1, b1, c1, d1} !== 7'b1000000 || p1 !== 1'b1 || ec1 !== 5'd0) begin
            failures++;
            $display("FAIL hold1_done: {done,busy,smp,abcd}=%b pass=%b err=%0d required 1000000 1 0",
                     {dn1, bz1, s1, a1, b1, c1, d1}, p1, ec1);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_check_faults();
        test_mid_reset();
        test_back_to_back();
        test_hold1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aoi4_stim_seq.md
# aoi4_stim_seq

Synchronous stimulus sequencer that sits directly upstream of the 4-input AND-OR-INVERT cell, `aoi_4`. It drives all 16 input combinations onto a, b, c and d and holds each one for a programmable number of clock cycles. It pulses a sample strobe at the end of each hold window. An optional compiled-in checker compares the AOI output against the expected value ~((a&b)|(c&d)) and reports a pass/fail verdict at the end of the sweep.

## Interface
Parameters:
- HOLD_CYCLES, default 100: cycles each vector is held. Legal range is 1..2^CNT_W.
- CNT_W, default 8: width of the hold counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a sweep. Sampled only in IDLE.
- mode  in  1  vector order: 0 = binary 0..15, 1 = Gray code of the index. Latched when start is accepted.
- y_in  in  1  AOI output under test. Ignored without the checker.
- a, b, c, d  out  1 each  stimulus; {a,b,c,d} is the 4-bit vector, with a as the MSB.
- vec_idx  out  4  index of the current vector.
- sample  out  1  high in the last cycle of each hold window.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse at the end of a sweep.
- err_cnt  out  5  mismatch count for the current or last sweep.
- pass  out  1  verdict of the last completed sweep.

## Operation
- Reset values: a=b=c=d=0, vec_idx=0, sample=0, busy=0, done=0, err_cnt=0, pass=0. FSM goes to IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - Outputs {a,b,c,d} = 0000.
  - On start=1: latch mode, clear vec_idx, the hold counter, err_cnt and pass, then go to RUN.
- RUN:
  - Outputs {a,b,c,d} = vec_idx when mode=0, or vec_idx ^ (vec_idx>>1) when mode=1.
  - The hold counter counts 0..HOLD_CYCLES-1. sample=1 when the counter equals HOLD_CYCLES-1.
  - In a sample cycle with vec_idx<15: increment vec_idx and clear the counter.
  - In a sample cycle with vec_idx=15: go to DONE.
- DONE:
  - done=1 and busy=0; {a,b,c,d} return to 0000.
  - pass is set to (err_cnt==0) and then holds until the next accepted start.
  - Go to IDLE after one cycle.
- start is ignored in RUN and DONE. There is no queuing; start must be reasserted in IDLE.
- mode changes after acceptance have no effect on the sweep in progress.
- rst_n=0 in any state, including mid-sweep, forces the reset values at the next edge. No done pulse is generated for the aborted sweep.

## Timing
- start is sampled at edge t. busy=1 and vector 0 are driven from edge t+1.
- Each vector is stable for exactly HOLD_CYCLES cycles.
- A vector change coincides with the edge that ends the previous sample cycle.
- busy stays high for exactly 16×HOLD_CYCLES cycles. done is high in the following cycle.
- The earliest restart is start sampled in the cycle after done. Sweep-to-sweep spacing is therefore 16×HOLD_CYCLES+2 cycles.
- HOLD_CYCLES=1: sample stays high for the whole sweep and the vector changes every cycle.
- The hold counter never exceeds HOLD_CYCLES-1 and wraps to 0 on every vector advance.

## Configuration
- Macro: AOI4_STIM_CHECK_EN.
- Defined:
  - In each sample cycle, y_in is compared with ~((a&b)|(c&d)) of the vector currently driven.
  - A mismatch increments err_cnt at that edge. The maximum is 16, so err_cnt never overflows.
  - pass reflects err_cnt==0, as described under Operation.
- Undefined:
  - y_in is unused and err_cnt is tied to 0.
  - pass is still set in DONE and therefore reads 1 after every completed sweep.
  - The sequencing and strobes are identical to the defined case.

## Test plan
- HOLD_CYCLES=4, mode=0, pulse start:
  - Vectors run 0000, 0001, …, 1111, each held 4 cycles.
  - 16 sample pulses, busy high for 64 cycles, then a single done pulse.
  - Outputs return to 0000.
- mode=1, HOLD_CYCLES=2:
  - Sequence is 0000, 0001, 0011, 0010, 0110, …, 1000.
  - vec_idx counts 0..15.
- CHECK_EN with y_in driven by a correct `aoi_4` model:
  - err_cnt=0 after the sweep, and pass=1 from the done cycle onward.
- CHECK_EN with faulty y_in:
  - y_in inverted → err_cnt=16, pass=0.
  - y_in stuck at 1 → err_cnt=7, pass=0.
- Reset and ignored start:
  - rst_n=0 for one cycle at vector 5 → next cycle all outputs are at reset values, with no done pulse.
  - start held high throughout a sweep → exactly one sweep runs, and a new sweep begins only after IDLE.
